// File: rtl/sr_cond_pkg.sv
// Shared constants and helpers for the SR pulse conditioner.
// Used by the top level and the per-button debounce channel.
package sr_cond_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter must be able to hold DEBOUNCE_CYCLES-1; clamp to one bit minimum
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser chain, debounce counter,
// debounced level and a registered single-cycle rising-edge pulse.
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;

  assign sync = chain[SYNC_STAGES-1];

  // The level flips, and the pulse fires, on the edge that sees the
  // DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      rise  <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
        rise  <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_pulse_conditioner.sv
// Front end for the SR flip-flop: two debounced button channels and
// clear-wins arbitration so S and R are never asserted together.
module sr_pulse_conditioner
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn_raw,
  input  logic clr_btn_raw,
  output logic S,
  output logic R,
  output logic set_level,
  output logic clr_level,
  output logic conflict
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("sr_pulse_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic set_rise;
  logic clr_rise;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk  (clk),
    .reset(reset),
    .raw  (set_btn_raw),
    .level(set_level),
    .rise (set_rise)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk  (clk),
    .reset(reset),
    .raw  (clr_btn_raw),
    .level(clr_level),
    .rise (clr_rise)
  );

  // Coincident edges: clear wins and the set edge is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= set_rise & ~clr_rise;
      R        <= clr_rise;
      conflict <= set_rise & clr_rise;
    end
  end

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// Self-checking bench for sr_pulse_conditioner: directed scenarios
// plus randomized button activity against a behavioural model.
module tb_sr_pulse_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic set_btn_raw = 1'b0;
  logic clr_btn_raw = 1'b0;
  logic S, R, set_level, clr_level, conflict;

  sr_pulse_conditioner #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .set_btn_raw(set_btn_raw),
    .clr_btn_raw(clr_btn_raw),
    .S          (S),
    .R          (R),
    .set_level  (set_level),
    .clr_level  (clr_level),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: raw history per button, debounced level, run of disagreeing samples
  bit hist_s[$];
  bit hist_c[$];
  bit m_lvl[2];
  int m_run[2];
  bit m_rise[2];
  bit m_s, m_r, m_cf;

  int s_cnt, r_cnt, cf_cnt, last_s, last_r;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_i(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_ch(int i, bit smp, output bit rs);
    rs = 1'b0;
    if (smp != m_lvl[i]) begin
      m_run[i]++;
      if (m_run[i] == DB) begin
        m_lvl[i] = smp;
        m_run[i] = 0;
        rs = smp;
      end
    end else begin
      m_run[i] = 0;
    end
  endtask

  task automatic model_edge(bit rst, bit s, bit c);
    bit smp_s, smp_c, rs, rc;
    if (rst) begin
      hist_s.delete();
      hist_c.delete();
      m_lvl = '{0, 0};
      m_run = '{0, 0};
      m_rise = '{0, 0};
      {m_s, m_r, m_cf} = 3'b000;
    end else begin
      m_s  = m_rise[0] & ~m_rise[1];
      m_r  = m_rise[1];
      m_cf = m_rise[0] & m_rise[1];
      smp_s = (hist_s.size() >= SS) ? hist_s[hist_s.size()-SS] : 1'b0;
      smp_c = (hist_c.size() >= SS) ? hist_c[hist_c.size()-SS] : 1'b0;
      model_ch(0, smp_s, rs);
      model_ch(1, smp_c, rc);
      m_rise[0] = rs;
      m_rise[1] = rc;
      hist_s.push_back(s);
      hist_c.push_back(c);
    end
  endtask

  task automatic step(bit rst, bit s, bit c);
    @(negedge clk);
    reset = rst;
    set_btn_raw = s;
    clr_btn_raw = c;
    @(posedge clk);
    cyc++;
    model_edge(rst, s, c);
    #1;
    chk("S", S, m_s);
    chk("R", R, m_r);
    chk("conflict", conflict, m_cf);
    chk("set_level", set_level, m_lvl[0]);
    chk("clr_level", clr_level, m_lvl[1]);
    chk("s_and_r", S & R, 1'b0);
    if (S) begin s_cnt++; last_s = cyc; end
    if (R) begin r_cnt++; last_r = cyc; end
    if (conflict) cf_cnt++;
  endtask

  task automatic clr_counts();
    s_cnt = 0; r_cnt = 0; cf_cnt = 0; last_s = -1; last_r = -1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    int k;
    int hs, hc;
    bit rs, rc;

    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_S", S, 1'b0);
    chk("reset_level", set_level, 1'b0);
    idle(3);

    // clean press
    clr_counts();
    step(0, 1, 0);
    k = cyc;
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    chk_i("t1_s_count", s_cnt, 1);
    chk_i("t1_s_time", last_s - k, 6);
    chk_i("t1_r_count", r_cnt, 0);
    idle(12);

    // bounce then stable
    clr_counts();
    step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    step(0, 1, 0);
    k = cyc;
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    chk_i("t2_s_count", s_cnt, 1);
    chk_i("t2_s_time", last_s - k, 6);
    idle(12);

    // 3-cycle glitch
    clr_counts();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    idle(12);
    chk_i("t2_glitch_count", s_cnt, 0);
    chk("t2_glitch_level", set_level, 1'b0);

    // simultaneous press
    clr_counts();
    for (int i = 0; i < 20; i++) step(0, 1, 1);
    chk_i("t3_s_count", s_cnt, 0);
    chk_i("t3_r_count", r_cnt, 1);
    chk_i("t3_cf_count", cf_cnt, 1);
    idle(12);

    // staggered presses
    clr_counts();
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1);
    chk_i("t4_s_count", s_cnt, 1);
    chk_i("t4_r_count", r_cnt, 1);
    chk_i("t4_gap", last_r - last_s, 2);
    chk_i("t4_cf_count", cf_cnt, 0);
    idle(12);

    // reset mid-debounce
    clr_counts();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(1, 1, 0);
    chk("t5_reset_S", S, 1'b0);
    step(0, 1, 0);
    k = cyc;
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    chk_i("t5_s_count", s_cnt, 1);
    chk_i("t5_s_time", last_s - k, 6);
    idle(12);

    // release and re-press
    clr_counts();
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(0, 0, 0);
    k = cyc;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0);
      if (cyc - k == 4) chk("t6_level_held", set_level, 1'b1);
      if (cyc - k == 5) chk("t6_level_fell", set_level, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    chk_i("t6_s_count", s_cnt, 2);
    idle(12);

    // randomized activity
    hs = 0; hc = 0; rs = 0; rc = 0;
    for (int i = 0; i < 600; i++) begin
      if (hs == 0) begin
        rs = 1'($urandom_range(1, 0));
        hs = $urandom_range(12, 1);
      end
      if (hc == 0) begin
        rc = 1'($urandom_range(1, 0));
        hc = $urandom_range(12, 1);
      end
      hs--;
      hc--;
      step($urandom_range(149, 0) == 0, rs, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
